// File: rtl/key_led_ctrl.sv
// Debounced pushbutton front end with per-channel LED modes (momentary, toggle,
// blink, latch) and a saturating press counter. Every output comes from a flop.
module key_led_ctrl #(
  parameter int unsigned NUM_KEYS     = 4,
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned BLINK_CYC    = 12500000,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [NUM_KEYS-1:0]   KEY,
  input  logic [2*NUM_KEYS-1:0] mode,
  input  logic                  clear,
  output logic [NUM_KEYS-1:0]   key_down,
  output logic [NUM_KEYS-1:0]   key_press,
  output logic [NUM_KEYS-1:0]   key_release,
  output logic [NUM_KEYS-1:0]   led,
  output logic [CNT_W-1:0]      press_count
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYC);
  localparam int unsigned BlW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  typedef enum logic [1:0] {
    ModeMomentary = 2'b00,
    ModeToggle    = 2'b01,
    ModeBlink     = 2'b10,
    ModeLatch     = 2'b11
  } led_mode_e;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [DbW-1:0]      db_cnt_q [NUM_KEYS];
  logic [DbW-1:0]      db_cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] down_q, down_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [NUM_KEYS-1:0] state_q, state_d;
  logic [NUM_KEYS-1:0] led_q, led_d;
  logic [BlW-1:0]      blink_cnt_q, blink_cnt_d;
  logic                blink_q, blink_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [3:0]          n_press;
  logic [CNT_W+3:0]    count_sum;
  led_mode_e           ch_mode;

  always_comb begin
    db_cnt_d    = db_cnt_q;
    down_d      = down_q;
    press_d     = '0;
    release_d   = '0;
    state_d     = state_q;
    led_d       = '0;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    n_press     = '0;
    ch_mode     = ModeMomentary;

    for (int i = 0; i < NUM_KEYS; i++) begin
      // KEY is active-low, so the synchronised pressed level is its inverse.
      if (~sync2_q[i] == down_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DbW'(DEBOUNCE_CYC - 1)) begin
        db_cnt_d[i]  = '0;
        down_d[i]    = ~sync2_q[i];
        press_d[i]   = ~sync2_q[i];
        release_d[i] = sync2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
      end

      ch_mode = led_mode_e'(mode[2*i +: 2]);

      // Momentary and blink modes leave the stored bit untouched.
      if (clear) begin
        state_d[i] = 1'b0;
      end else if (press_q[i]) begin
        unique case (ch_mode)
          ModeToggle: state_d[i] = ~state_q[i];
          ModeLatch:  state_d[i] = 1'b1;
          default:    state_d[i] = state_q[i];
        endcase
      end

      unique case (ch_mode)
        ModeMomentary: led_d[i] = down_q[i];
        ModeBlink:     led_d[i] = down_q[i] & blink_q;
        default:       led_d[i] = state_q[i];
      endcase

      n_press = n_press + 4'(press_q[i]);
    end

    if (blink_cnt_q == BlW'(BLINK_CYC - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BlW'(1);
    end

    count_sum = {4'b0, count_q} + {{CNT_W{1'b0}}, n_press};
    count_d   = (count_sum > {4'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : count_sum[CNT_W-1:0];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      for (int i = 0; i < NUM_KEYS; i++) db_cnt_q[i] <= '0;
      down_q      <= '0;
      press_q     <= '0;
      release_q   <= '0;
      state_q     <= '0;
      led_q       <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      sync1_q     <= KEY;
      sync2_q     <= sync1_q;
      for (int i = 0; i < NUM_KEYS; i++) db_cnt_q[i] <= db_cnt_d[i];
      down_q      <= down_d;
      press_q     <= press_d;
      release_q   <= release_d;
      state_q     <= state_d;
      led_q       <= led_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      count_q     <= count_d;
    end
  end

  assign key_down    = down_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign led         = led_q;
  assign press_count = count_q;

endmodule

// File: doc/key_led_ctrl.md
KEY_LED_CTRL -- requirements
Module: key_led_ctrl

Interface
REQ-001 Parameter NUM_KEYS, default 4, number of independent key channels (1..10).
REQ-002 Parameter DEBOUNCE_CYC, default 500000, consecutive stable cycles required to accept a new key level (10 ms at 50 MHz); minimum 2.
REQ-003 Parameter BLINK_CYC, default 12500000, half-period in cycles of the shared blink phase; minimum 1.
REQ-004 Parameter CNT_W, default 8, width of the press counter.
REQ-005 Port CLOCK_50  input  1  sole clock; all state updates on the rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port KEY  input  NUM_KEYS  raw asynchronous pushbuttons, active-low (0 = pressed).
REQ-008 Port mode  input  2*NUM_KEYS  per-channel LED mode; bits [2i+1:2i] select channel i.
REQ-009 Port clear  input  1  synchronous clear of toggle/latch LED state.
REQ-010 Port key_down  output  NUM_KEYS  debounced level, active-high (1 = pressed).
REQ-011 Port key_press  output  NUM_KEYS  one-cycle pulse on each debounced press.
REQ-012 Port key_release  output  NUM_KEYS  one-cycle pulse on each debounced release.
REQ-013 Port led  output  NUM_KEYS  per-channel LED drive, active-high.
REQ-014 Port press_count  output  CNT_W  saturating total of debounced presses across all channels.

Function
REQ-015 Each KEY bit shall pass through a two-flop synchroniser that resets to 1 (released).
REQ-016 Each channel shall hold a debounce counter that resets to 0 on any cycle where the synchronised level equals the accepted level and increments otherwise.
REQ-017 The accepted level shall flip on the edge where the counter would reach DEBOUNCE_CYC; the counter then returns to 0.
REQ-018 Latency from a clean KEY edge to the key_down change shall be exactly DEBOUNCE_CYC+2 cycles.
REQ-019 A glitch shorter than DEBOUNCE_CYC synchronised cycles shall produce no change on any output.
REQ-020 key_press[i] / key_release[i] shall be registered and high for exactly one cycle, in the same cycle key_down[i] first shows the new level.
REQ-021 mode 00 (momentary): led[i] = key_down[i].
REQ-022 mode 01 (toggle): led[i] flips state on each key_press[i].
REQ-023 mode 10 (blink): led[i] = key_down[i] AND blink phase.
REQ-024 mode 11 (latch): led[i] is set by key_press[i] and held until clear.
REQ-025 Toggle and latch share one state bit per channel; in mode 00 and 10 that bit is preserved but not shown.
REQ-026 A mode change shall take effect on the led output in the next cycle without altering stored state.
REQ-027 The blink phase shall be a single shared bit that inverts every BLINK_CYC cycles, giving period 2*BLINK_CYC; it resets to 0.
REQ-028 clear shall zero all state bits; clear has priority over a key_press in the same cycle for LED state.
REQ-029 A press coinciding with clear shall still be counted and still pulse key_press.
REQ-030 press_count shall add the number of key_press bits asserted in a cycle (simultaneous presses count individually).
REQ-031 press_count shall saturate at 2^CNT_W-1 and never wrap; only reset zeroes it.
REQ-032 All outputs shall be registered; no combinational path from KEY to any output.

Reset
REQ-033 While reset is high: synchronisers = 1, debounce counters = 0, key_down = 0, key_press = 0, key_release = 0, state bits = 0, blink phase = 0, blink counter = 0, press_count = 0.
REQ-034 LED outputs shall be 0 during reset and in the first cycle after release.
REQ-035 Reset asserted mid-debounce shall discard the partial count; a key held through reset release shall be accepted DEBOUNCE_CYC+2 cycles after release, producing a key_press pulse.

Verification (bench uses NUM_KEYS=4, DEBOUNCE_CYC=4, BLINK_CYC=3, CNT_W=3)
REQ-036 KEY[0] held low from cycle 10 -> key_down[0] rises at cycle 16; key_press[0] high only in cycle 16.
REQ-037 KEY[1] low for 3 cycles then high -> no change on key_down, key_press, led, or press_count.
REQ-038 mode=01 on channel 2; press/release twice -> led[2] goes 1 after first press, 0 after second.
REQ-039 mode=11 on channel 3; press, then clear pulse in the same cycle as a second key_press -> led[3] = 0 after clear; press_count = 2.
REQ-040 All four keys pressed simultaneously, twice -> press_count 4, then 7 (saturated).
REQ-041 mode=10, key held -> led toggles every 3 cycles while held, 0 after release; reset asserted mid-hold -> all outputs 0 next cycle.
